// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial add controller.
//   state_t    : controller FSM states
//   cnt_width  : width of a counter that can hold 0..w
//   REQ0/REQ1  : requester identifiers as carried on rsp_id
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    RESP
  } state_t;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/serial_add_ctrl_fa_bit.sv
// One-bit full-adder cell; the single adder resource shared by both requesters.
//   a, b, cin : addend bits and carry in
//   s, cout   : sum bit and carry out
module fa_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  always_comb begin
    s    = a ^ b ^ cin;
    cout = (a & b) | (a & cin) | (b & cin);
  end

endmodule

// File: rtl/serial_add_ctrl.sv
// Two-requester front end for a bit-serial adder. Jobs are accepted through
// per-requester valid/ready, arbitrated round-robin, added LSB-first through
// one fa_bit cell at one bit per cycle, and returned on a response handshake.
//   clk, rst                     : clock, synchronous active-high reset
//   reqN_valid/ready             : job handshake for requester N (N = 0, 1)
//   reqN_a, reqN_b, reqN_cin     : job operands, sampled only on accept
//   rsp_valid/ready              : result handshake
//   rsp_sum, rsp_cout, rsp_id    : a+b+cin (low WIDTH bits), carry out, issuer
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_cin,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_cin,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout,
  output logic             rsp_id
);

  localparam int unsigned CW = cnt_width(WIDTH);

  state_t           state;
  logic             last_grant;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             carry;
  logic [CW-1:0]    count;
  logic             id;

  logic             grant0;
  logic             grant1;
  logic             fa_s;
  logic             fa_c;

  // On a tie the requester that was not served last wins.
  always_comb begin
    grant0     = req0_valid & (~req1_valid | (last_grant == REQ1));
    grant1     = req1_valid & ~grant0;
    req0_ready = (state == IDLE) & grant0 & ~rst;
    req1_ready = (state == IDLE) & grant1 & ~rst;
  end

  fa_bit u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_c)
  );

  // rsp_sum doubles as the sum shift register; it is only observable while
  // rsp_valid is high, by which point all WIDTH bits have been shifted in.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= REQ1;
      a_sh       <= '0;
      b_sh       <= '0;
      carry      <= 1'b0;
      count      <= '0;
      id         <= REQ0;
      rsp_valid  <= 1'b0;
      rsp_sum    <= '0;
      rsp_cout   <= 1'b0;
      rsp_id     <= REQ0;
    end else begin
      case (state)
        IDLE: begin
          if (grant0) begin
            a_sh       <= req0_a;
            b_sh       <= req0_b;
            carry      <= req0_cin;
            id         <= REQ0;
            last_grant <= REQ0;
            count      <= '0;
            state      <= ADD;
          end else if (grant1) begin
            a_sh       <= req1_a;
            b_sh       <= req1_b;
            carry      <= req1_cin;
            id         <= REQ1;
            last_grant <= REQ1;
            count      <= '0;
            state      <= ADD;
          end
        end
        ADD: begin
          a_sh    <= a_sh >> 1;
          b_sh    <= b_sh >> 1;
          rsp_sum <= {fa_s, rsp_sum[WIDTH-1:1]};
          carry   <= fa_c;
          count   <= count + CW'(1);
          if (count == CW'(WIDTH - 1)) begin
            rsp_cout  <= fa_c;
            rsp_id    <= id;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
module tb_serial_add_ctrl;

  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // WIDTH=8 instance
  logic         r0v, r0r, r0c, r1v, r1r, r1c;
  logic [W-1:0] r0a, r0b, r1a, r1b;
  logic         rv, rr, rc, rid;
  logic [W-1:0] rs;

  // WIDTH=2 instance
  logic       s0v, s0r, s0c, s1v, s1r, s1c;
  logic [1:0] s0a, s0b, s1a, s1b;
  logic       sv, sr, sc, sid;
  logic [1:0] ss;

  serial_add_ctrl #(.WIDTH(W)) dut8 (
    .clk(clk), .rst(rst),
    .req0_valid(r0v), .req0_ready(r0r), .req0_a(r0a), .req0_b(r0b), .req0_cin(r0c),
    .req1_valid(r1v), .req1_ready(r1r), .req1_a(r1a), .req1_b(r1b), .req1_cin(r1c),
    .rsp_valid(rv), .rsp_ready(rr), .rsp_sum(rs), .rsp_cout(rc), .rsp_id(rid)
  );

  serial_add_ctrl #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst),
    .req0_valid(s0v), .req0_ready(s0r), .req0_a(s0a), .req0_b(s0b), .req0_cin(s0c),
    .req1_valid(s1v), .req1_ready(s1r), .req1_a(s1a), .req1_b(s1b), .req1_cin(s1c),
    .rsp_valid(sv), .rsp_ready(sr), .rsp_sum(ss), .rsp_cout(sc), .rsp_id(sid)
  );

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model for the WIDTH=8 instance: outstanding job, round-robin
  // memory, and handshake history.
  typedef struct {
    logic        id;
    logic [W:0]  res;
    int unsigned t;
  } job_t;

  job_t        q[$];
  int unsigned cyc = 0;
  logic        m_last = 1'b1;
  bit          seen = 1'b0;
  bit          chk_gap = 1'b0;
  bit          have_prev = 1'b0;
  int unsigned prev_acc = 0;
  int unsigned acc_cyc = 0;
  int unsigned hs_cyc = 0;
  int unsigned acc_cnt = 0;
  int unsigned n_rsp = 0;
  logic        last_acc_id = 1'b0;
  logic        acc_ids[$];
  logic [W-1:0] last_sum = '0;
  logic        last_cout = 1'b0;
  logic        e0, e1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic model_accept(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic c);
    job_t j;
    j.id  = id;
    j.res = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    j.t   = cyc;
    q.push_back(j);
    m_last = id;
    if (chk_gap && have_prev) check_eq("accept_gap", cyc - prev_acc, W + 2);
    prev_acc    = cyc;
    have_prev   = 1'b1;
    acc_cyc     = cyc;
    last_acc_id = id;
    acc_ids.push_back(id);
    acc_cnt++;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      m_last    = 1'b1;
      seen      = 1'b0;
      have_prev = 1'b0;
    end
    e0 = !rst && q.size() == 0 && r0v && (!r1v || m_last);
    e1 = !rst && q.size() == 0 && r1v && (!r0v || !m_last);
    check_eq("req0_ready", r0r, e0);
    check_eq("req1_ready", r1r, e1);
    if (!rst) begin
      if (rv) begin
        if (q.size() == 0) begin
          check_eq("unexpected_rsp", rv, 1'b0);
        end else begin
          if (!seen) begin
            check_eq("latency", cyc - q[0].t, W + 1);
            seen = 1'b1;
          end
          check_eq("rsp_sum", rs, q[0].res[W-1:0]);
          check_eq("rsp_cout", rc, q[0].res[W]);
          check_eq("rsp_id", rid, q[0].id);
          if (rr) begin
            last_sum  = rs;
            last_cout = rc;
            hs_cyc    = cyc;
            n_rsp++;
            seen = 1'b0;
            void'(q.pop_front());
          end
        end
      end
      if (r0v && r0r) model_accept(1'b0, r0a, r0b, r0c);
      else if (r1v && r1r) model_accept(1'b1, r1a, r1b, r1c);
    end
  end

  task automatic drive_pt();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_acc(input int unsigned target);
    int n = 0;
    while (acc_cnt < target && n < 60) begin
      @(negedge clk);
      #1;
      n++;
    end
    check_eq("accept_wait", acc_cnt, target);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (q.size() != 0 && n < 80) begin
      @(negedge clk);
      #1;
      n++;
    end
    check_eq("drain", q.size(), 0);
  endtask

  task automatic job8(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic c, input logic [W-1:0] exp_sum, input logic exp_cout);
    int unsigned start;
    drive_pt();
    rr = 1'b1;
    r0v = 1'b1; r0a = a; r0b = b; r0c = c;
    start = acc_cnt;
    wait_acc(start + 1);
    drive_pt();
    r0v = 1'b0;
    r0a = W'($urandom); r0b = W'($urandom); r0c = 1'($urandom);
    wait_drain();
    check_eq({tag, "_sum"}, last_sum, exp_sum);
    check_eq({tag, "_cout"}, last_cout, exp_cout);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int unsigned start;
    int unsigned saved;
    int n;
    bit ok;
    logic [1:0] ea, eb;
    logic ec, eid;
    logic [2:0] ex;

    r0v = 0; r0a = '0; r0b = '0; r0c = 0;
    r1v = 0; r1a = '0; r1b = '0; r1c = 0;
    rr  = 1;
    s0v = 0; s0a = '0; s0b = '0; s0c = 0;
    s1v = 0; s1a = '0; s1b = '0; s1c = 0;
    sr  = 1;

    // Contention from reset release: both valid throughout reset.
    r0v = 1; r1v = 1;
    r0a = 8'h11; r0b = 8'h22; r1a = 8'h33; r1b = 8'h44;
    chk_gap = 1;
    repeat (3) drive_pt();
    rst = 0;
    @(negedge clk);
    #1;
    check_eq("reset_rsp_valid", rv, 1'b0);
    check_eq("reset_rsp_sum", rs, 0);
    check_eq("reset_rsp_cout", rc, 1'b0);
    check_eq("reset_rsp_id", rid, 1'b0);
    wait_acc(4);
    check_eq("rr_grant0", acc_ids[0], 1'b0);
    check_eq("rr_grant1", acc_ids[1], 1'b1);
    check_eq("rr_grant2", acc_ids[2], 1'b0);
    check_eq("rr_grant3", acc_ids[3], 1'b1);
    drive_pt();
    r0v = 0; r1v = 0; chk_gap = 0;
    wait_drain();

    // Directed single add and carry cases.
    job8("single", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0);
    job8("carry_ff01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    job8("carry_ffff", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
    job8("cin_only", 8'h00, 8'h00, 1'b1, 8'h01, 1'b0);

    // Backpressure with a waiting requester 1.
    drive_pt();
    rr = 0;
    r0v = 1; r0a = W'($urandom); r0b = W'($urandom); r0c = 1'($urandom);
    start = acc_cnt;
    wait_acc(start + 1);
    drive_pt();
    r0v = 0;
    r1v = 1; r1a = W'($urandom); r1b = W'($urandom); r1c = 1'($urandom);
    n = 0;
    while (!rv && n < 30) begin
      @(negedge clk);
      #1;
      n++;
    end
    check_eq("bp_rsp_seen", rv, 1'b1);
    repeat (5) drive_pt();
    rr = 1;
    wait_acc(start + 2);
    check_eq("bp_next_accept", acc_cyc - hs_cyc, 1);
    check_eq("bp_next_id", last_acc_id, 1'b1);
    drive_pt();
    r1v = 0;
    wait_drain();

    // Reset during ADD on a requester-0 job.
    drive_pt();
    r0v = 1; r0a = W'($urandom); r0b = W'($urandom); r0c = 1'($urandom);
    start = acc_cnt;
    wait_acc(start + 1);
    drive_pt();
    r0v = 0;
    repeat (3) drive_pt();
    rst = 1;
    drive_pt();
    rst = 0;
    saved = n_rsp;
    @(negedge clk);
    #1;
    check_eq("midrst_rsp_valid", rv, 1'b0);
    check_eq("midrst_rsp_sum", rs, 0);
    check_eq("midrst_rsp_cout", rc, 1'b0);
    check_eq("midrst_rsp_id", rid, 1'b0);
    repeat (W + 4) @(negedge clk);
    check_eq("midrst_no_rsp", n_rsp, saved);
    drive_pt();
    r0v = 1; r0a = 8'h01; r0b = 8'h02; r0c = 0;
    r1v = 1; r1a = W'($urandom); r1b = W'($urandom); r1c = 1'($urandom);
    start = acc_cnt;
    wait_acc(start + 1);
    check_eq("midrst_winner", last_acc_id, 1'b0);
    drive_pt();
    r0v = 0; r1v = 0;
    wait_drain();
    check_eq("midrst_sum", last_sum, 8'h03);

    // Randomized traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      drive_pt();
      r0v = ($urandom_range(0, 3) != 0);
      r1v = ($urandom_range(0, 3) != 0);
      r0a = W'($urandom); r0b = W'($urandom); r0c = 1'($urandom);
      r1a = W'($urandom); r1b = W'($urandom); r1c = 1'($urandom);
      rr  = ($urandom_range(0, 2) != 0);
    end
    drive_pt();
    r0v = 0; r1v = 0; rr = 1;
    wait_drain();

    // Exhaustive WIDTH=2 on alternating requesters.
    for (int i = 0; i < 32; i++) begin
      ea  = 2'(i >> 3);
      eb  = 2'(i >> 1);
      ec  = 1'(i);
      eid = 1'(i % 2);
      ex  = {1'b0, ea} + {1'b0, eb} + {2'b00, ec};
      drive_pt();
      if (eid) begin
        s1v = 1; s1a = ea; s1b = eb; s1c = ec;
      end else begin
        s0v = 1; s0a = ea; s0b = eb; s0c = ec;
      end
      ok = 0;
      n = 0;
      while (!ok && n < 8) begin
        @(negedge clk);
        #1;
        ok = eid ? s1r : s0r;
        n++;
      end
      check_eq("w2_accept", ok, 1'b1);
      drive_pt();
      s0v = 0; s1v = 0;
      ok = 0;
      n = 0;
      while (!ok && n < 8) begin
        @(negedge clk);
        #1;
        ok = sv;
        n++;
      end
      check_eq("w2_rsp_valid", ok, 1'b1);
      check_eq("w2_sum", ss, ex[1:0]);
      check_eq("w2_cout", sc, ex[2]);
      check_eq("w2_id", sid, eid);
    end
    drive_pt();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Controller that shares one bit-serial full-adder cell between two requesters. Each requester hands over a WIDTH-bit add job (a, b, carry-in) through a valid/ready handshake. The block arbitrates round-robin and runs the add LSB-first through the cell, one bit per cycle. It returns sum, carry-out and requester id on a response handshake. It sits between client logic and the shared adder cell, trading latency for area.

## Interface
- WIDTH, 8, operand/sum width in bits (>= 2)
- clk  in  1  rising-edge clock
- rst  in  1  reset; synchronous, active-high
- req0_valid  in  1  requester 0 has a job
- req0_ready  out  1  requester 0 job accepted this cycle when valid & ready
- req0_a, req0_b  in  WIDTH  requester 0 operands
- req0_cin  in  1  requester 0 carry-in
- req1_valid, req1_ready, req1_a, req1_b, req1_cin: same as requester 0, for requester 1
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer takes result when valid & ready
- rsp_sum  out  WIDTH  (a + b + cin) mod 2^WIDTH
- rsp_cout  out  1  bit WIDTH of a + b + cin
- rsp_id  out  1  requester that issued the job

## Operation
- States: IDLE, ADD, RESP. Reset state is IDLE.
- IDLE:
  - The grant goes to the single valid requester. If both are valid, it goes to the one not granted last.
  - last_grant resets to 1, so requester 0 wins the first tie.
  - reqN_ready = (state==IDLE) & grantN & !rst. It is combinational from valids and last_grant, and ready never depends on rsp_ready.
  - On accept: load a and b shift registers and carry = cin. Clear bit counter. Latch id. Update last_grant. Go to ADD.
- ADD, each cycle:
  - fa_bit computes s, c from a[0], b[0], carry.
  - Shift a and b right. Shift s into sum at the MSB. carry <= c. count++.
  - After the WIDTH-th bit, go to RESP.
- RESP:
  - rsp_valid = 1, with rsp_sum, rsp_cout and rsp_id stable.
  - Both readies are low.
  - On rsp_valid & rsp_ready, go to IDLE.
- Requester inputs are sampled only in the accept cycle. Later changes have no effect.
- A requester that drops valid before being granted is simply not served. Its requests are not queued.
- Arithmetic is unsigned. Overflow shows up only in rsp_cout, never as an error.

## Timing
- Reset values:
  - rsp_valid = 0, rsp_sum = 0, rsp_cout = 0, rsp_id = 0.
  - req0_ready = req1_ready = 0 while rst is high.
  - state = IDLE, last_grant = 1, count = 0.
- rst asserted in any state, including mid-ADD or RESP: at the next edge all of the above reset values apply, and any in-flight job is dropped with no response.
- Latency: with the accept handshake in cycle T, rsp_valid first rises in cycle T + WIDTH + 1.
- Minimum job spacing is WIDTH + 2 cycles (accept, WIDTH add cycles, response cycle with rsp_ready = 1). The next accept can occur in the cycle after the response handshake.
- Backpressure: rsp_ready low holds RESP indefinitely, with outputs frozen and no accepts.
- Simultaneous valids in IDLE: exactly one ready is asserted. The loser's valid may stay high and it wins the next arbitration.

## Structure
- Package serial_add_pkg:
  - state typedef (IDLE, ADD, RESP).
  - Counter-width function $clog2(WIDTH+1).
  - Requester-id constants REQ0 = 0, REQ1 = 1.
- Sub-module fa_bit: one-bit combinational full-adder cell (a, b, cin -> s, cout), instantiated once. This is the shared resource.
- Top contains the arbiter, FSM, shift registers, counter and response registers.

## Test plan
- Single add, WIDTH=8:
  - Stimulus: req0 a=0x5A, b=0x3C, cin=0.
  - Required: rsp_sum=0x96, rsp_cout=0, rsp_id=0, and rsp_valid rises exactly 9 cycles after accept.
- Carry cases:
  - a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1.
  - a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
  - a=0x00, b=0x00, cin=1 -> sum=0x01, cout=0.
- Contention:
  - Stimulus: req0 and req1 both valid continuously from reset release, rsp_ready=1.
  - Required: grants alternate 0,1,0,1. rsp_id matches. Accepts are spaced 10 cycles apart.
- Backpressure:
  - Stimulus: rsp_ready low for 5 cycles in RESP, with req1 valid.
  - Required: response fields stable, req1_ready=0 throughout, req1 accepted the cycle after the response handshake.
- Mid-operation reset:
  - Stimulus: rst for 1 cycle after 3 ADD cycles.
  - Required: no response emitted. Next req0 a=0x01, b=0x02 returns sum=0x03 and wins arbitration as if from reset.
- Exhaustive, WIDTH=2: all 32 (a, b, cin) combinations on alternating requesters; every response matches a + b + cin.
